// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
// Optional build macro: WBARB_WAW_KILL_EN (pipeline write kills older buffered MDU results to the same rd).
package wb_arb_pkg;

  localparam int unsigned DEPTH_DEF        = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned REG_W            = 5;

  // One buffered MDU result.
  typedef struct packed {
    logic                  valid;
    logic [REG_W-1:0]      rd;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  // Source that owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_BUF  = 2'd2,
    GNT_BYP  = 2'd3
  } gnt_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// In-order circular buffer for MDU results with per-entry valid clear.
// Optional build macro: WBARB_WAW_KILL_EN (exposes per-entry rd for kill matching).
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [REG_W-1:0]         push_rd,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic [DEPTH-1:0]         kill,
`ifdef WBARB_WAW_KILL_EN
  output logic [DEPTH*REG_W-1:0]   ent_rd,
`endif
  output logic                     head_valid,
  output logic [REG_W-1:0]         head_rd,
  output logic [DATA_W-1:0]        head_data,
  output logic                     empty,
  output logic                     full,
  output logic                     any_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  valid_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Valid bits: kill first, then pop clears the head, push sets the new slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q & ~kill;
      if (pop)  valid_q[rd_ptr] <= 1'b0;
      if (push) valid_q[wr_ptr] <= 1'b1;
    end
  end

  // Payload storage needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= push_rd;
      data_q[wr_ptr] <= push_data;
    end
  end

`ifdef WBARB_WAW_KILL_EN
  // Flattened destination registers for the kill comparison at the top.
  always_comb begin
    ent_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) ent_rd[i*REG_W +: REG_W] = rd_q[i];
  end
`endif

  assign head_valid = valid_q[rd_ptr];
  assign head_rd    = rd_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign any_valid  = |valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback first, buffered MDU results second,
// direct MDU bypass when the buffer is empty. Starvation raises a one-cycle bubble request.
// Optional build macro: WBARB_WAW_KILL_EN (pipeline write discards older buffered result to same rd).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [4:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              busy
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  gnt_e              gnt;
  logic              pipe_req;
  logic              byp_req;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  kill;
  logic              head_valid;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic              empty;
  logic              full;
  logic              any_valid;
  logic [SC_W-1:0]   starve_cnt;
`ifdef WBARB_WAW_KILL_EN
  logic [DEPTH*REG_W-1:0] ent_rd;
`endif

  assign pipe_req = RegWriteW && (RdW != '0);
  assign byp_req  = empty && mdu_valid && (mdu_rd != '0);

  // Fixed-priority grant; nothing is granted while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      if (pipe_req)        gnt = GNT_PIPE;
      else if (head_valid) gnt = GNT_BUF;
      else if (byp_req)    gnt = GNT_BYP;
    end
  end

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign mdu_ready = rst && !full;

  // x0 results are accepted but never stored; bypassed results skip the buffer.
  assign push = mdu_valid && mdu_ready && (mdu_rd != '0) && (gnt != GNT_BYP);
  // A killed head drains on any idle write cycle.
  assign pop  = (gnt == GNT_BUF) || ((gnt == GNT_NONE) && !empty && !head_valid);

  // Kill vector: pipeline write to the same rd retires older buffered results.
  always_comb begin
    kill = '0;
`ifdef WBARB_WAW_KILL_EN
    for (int unsigned i = 0; i < DEPTH; i++)
      kill[i] = (gnt == GNT_PIPE) && (ent_rd[i*REG_W +: REG_W] == RdW);
`endif
  end

  wb_arb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (mdu_rd),
    .push_data  (mdu_data),
    .pop        (pop),
    .kill       (kill),
`ifdef WBARB_WAW_KILL_EN
    .ent_rd     (ent_rd),
`endif
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .empty      (empty),
    .full       (full),
    .any_valid  (any_valid)
  );

  // Write port mux driven straight from the grant; the register file captures at the next edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (gnt)
      GNT_PIPE: begin rf_we = 1'b1; rf_waddr = RdW;     rf_wdata = ResultW;   end
      GNT_BUF:  begin rf_we = 1'b1; rf_waddr = head_rd; rf_wdata = head_data; end
      GNT_BYP:  begin rf_we = 1'b1; rf_waddr = mdu_rd;  rf_wdata = mdu_data;  end
      default:  ;
    endcase
  end

  // Starve counter: counts denied cycles of a valid head, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!head_valid || (gnt == GNT_BUF)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  assign stall_req = head_valid && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign busy      = any_valid;

endmodule
